bip_control: RTL and testbench

- Control unit of the BIP-I accumulator processor; the instruction-side counterpart that drives the datapath's control inputs.
- Holds the program counter and addresses program memory.
- Decodes each 16-bit instruction into the datapath controls: selA, selB, WrAcc, Op and operand, plus the data-memory read and write strobes.
- Runs under a start/done handshake from the UART debug unit, and reports PC and a cycle count.

---
 rtl/bip_control.sv | 172 +++++++++++++++++
 tb/tb_bip_control.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bip_control.sv
// bip_control: control unit of the BIP-I accumulator processor.
// Holds the program counter, decodes each 16-bit instruction into the
// datapath controls, and runs under a start/done handshake with a
// saturating cycle counter.
// Optional build macro BIP_STEP_MODE_EN adds an i_step input; in RUN an
// instruction then executes only in cycles where i_step is high.
module bip_control #(
  parameter int PC_WIDTH     = 11,
  parameter int DATA_WIDTH   = 16,
  parameter int OPCODE_WIDTH = 5,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
`ifdef BIP_STEP_MODE_EN
  input  logic                  i_step,
`endif
  input  logic [DATA_WIDTH-1:0] i_instr,
  output logic [PC_WIDTH-1:0]   o_addr_pm,
  output logic [PC_WIDTH-1:0]   o_operand,
  output logic [1:0]            o_selA,
  output logic                  o_selB,
  output logic                  o_WrAcc,
  output logic                  o_Op,
  output logic                  o_WrRam,
  output logic                  o_RdRam,
  output logic                  o_done,
  output logic [CNT_WIDTH-1:0]  o_cycles
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [OPCODE_WIDTH-1:0] OP_HLT  = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] OP_STO  = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] OP_LD   = OPCODE_WIDTH'(2);
  localparam logic [OPCODE_WIDTH-1:0] OP_LDI  = OPCODE_WIDTH'(3);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD  = OPCODE_WIDTH'(4);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDI = OPCODE_WIDTH'(5);
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB  = OPCODE_WIDTH'(6);
  localparam logic [OPCODE_WIDTH-1:0] OP_SUBI = OPCODE_WIDTH'(7);

  state_t                  state;
  state_t                  state_next;
  logic [PC_WIDTH-1:0]     pc;
  logic [CNT_WIDTH-1:0]    cycles;
  logic [OPCODE_WIDTH-1:0] opcode;
  logic                    exec;
  logic                    is_hlt;

  assign opcode = i_instr[DATA_WIDTH-1 -: OPCODE_WIDTH];
  assign is_hlt = (opcode == OP_HLT);

`ifdef BIP_STEP_MODE_EN
  assign exec = (state == RUN) && i_step;
`else
  assign exec = (state == RUN);
`endif

  assign o_addr_pm = pc;
  assign o_cycles  = cycles;
  assign o_done    = (state == HALT);

  // State register; reset aborts any run and returns to IDLE.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: start leaves IDLE/HALT, an executed HLT ends the run.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (i_start) state_next = RUN;
      RUN:     if (exec && is_hlt) state_next = HALT;
      HALT:    if (i_start) state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  // Program counter and cycle counter; HLT is counted but does not advance PC.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      pc     <= '0;
      cycles <= '0;
    end else begin
      case (state)
        IDLE: pc <= '0;
        RUN: begin
          if (exec) begin
            if (cycles != '1) cycles <= cycles + 1'b1;
            if (!is_hlt) pc <= pc + 1'b1;
          end
        end
        HALT: begin
          if (i_start) begin
            pc     <= '0;
            cycles <= '0;
          end
        end
        default: begin
          pc     <= '0;
          cycles <= '0;
        end
      endcase
    end
  end

  // Instruction decode; everything stays low unless an instruction executes.
  always_comb begin
    o_operand = '0;
    o_selA    = 2'd0;
    o_selB    = 1'b0;
    o_WrAcc   = 1'b0;
    o_Op      = 1'b0;
    o_WrRam   = 1'b0;
    o_RdRam   = 1'b0;
    if (state == RUN) begin
      o_operand = i_instr[PC_WIDTH-1:0];
    end
    if (exec) begin
      case (opcode)
        OP_STO: o_WrRam = 1'b1;
        OP_LD: begin
          o_RdRam = 1'b1;
          o_selA  = 2'd0;
          o_WrAcc = 1'b1;
        end
        OP_LDI: begin
          o_selA  = 2'd1;
          o_WrAcc = 1'b1;
        end
        OP_ADD: begin
          o_RdRam = 1'b1;
          o_selA  = 2'd2;
          o_selB  = 1'b0;
          o_Op    = 1'b1;
          o_WrAcc = 1'b1;
        end
        OP_ADDI: begin
          o_selA  = 2'd2;
          o_selB  = 1'b1;
          o_Op    = 1'b1;
          o_WrAcc = 1'b1;
        end
        OP_SUB: begin
          o_RdRam = 1'b1;
          o_selA  = 2'd2;
          o_selB  = 1'b0;
          o_Op    = 1'b0;
          o_WrAcc = 1'b1;
        end
        OP_SUBI: begin
          o_selA  = 2'd2;
          o_selB  = 1'b1;
          o_Op    = 1'b0;
          o_WrAcc = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bip_control.sv
// Testbench for bip_control: directed programs with hand-computed expectations.
module tb_bip_control;

  logic        i_clk;
  logic        i_rst;
  logic        i_start;
  logic        i_step;
  logic [15:0] i_instr;
  logic [10:0] o_addr_pm;
  logic [10:0] o_operand;
  logic [1:0]  o_selA;
  logic        o_selB;
  logic        o_WrAcc;
  logic        o_Op;
  logic        o_WrRam;
  logic        o_RdRam;
  logic        o_done;
  logic [15:0] o_cycles;

  logic [15:0] pm [0:2047];

  int total;
  int bad;

  bip_control dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_start   (i_start),
`ifdef BIP_STEP_MODE_EN
    .i_step    (i_step),
`endif
    .i_instr   (i_instr),
    .o_addr_pm (o_addr_pm),
    .o_operand (o_operand),
    .o_selA    (o_selA),
    .o_selB    (o_selB),
    .o_WrAcc   (o_WrAcc),
    .o_Op      (o_Op),
    .o_WrRam   (o_WrRam),
    .o_RdRam   (o_RdRam),
    .o_done    (o_done),
    .o_cycles  (o_cycles)
  );

  // Combinational program-memory model
  assign i_instr = pm[o_addr_pm];

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse start across one rising edge and land on the following falling edge
  task automatic applyStimulus();
    i_start = 1'b1;
    @(posedge i_clk);
    #1 i_start = 1'b0;
    @(negedge i_clk);
  endtask

  task automatic doReset();
    @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
  endtask

  task automatic fillPm(input logic [15:0] word);
    for (int i = 0; i < 2048; i++) pm[i] = word;
  endtask

  task automatic loadProg1();
    fillPm(16'h0000);
    pm[0] = {5'b00011, 11'd5};
    pm[1] = {5'b00101, 11'd3};
    pm[2] = {5'b00111, 11'd1};
    pm[3] = 16'h0000;
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    i_rst   = 1'b0;
    i_start = 1'b0;
    i_step  = 1'b1;
    loadProg1();

    // Reset state
    #1;
    checkOutput("rst_addr", 32'(o_addr_pm), 0);
    checkOutput("rst_done", 32'(o_done), 0);
    checkOutput("rst_cycles", 32'(o_cycles), 0);
    checkOutput("rst_operand", 32'(o_operand), 0);
    checkOutput("rst_wracc", 32'(o_WrAcc), 0);
    @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    checkOutput("idle_wracc", 32'(o_WrAcc), 0);
    checkOutput("idle_operand", 32'(o_operand), 0);

    // Program 1: LDI 5; ADDI 3; SUBI 1; HLT
    applyStimulus();
    checkOutput("p1c0_addr", 32'(o_addr_pm), 0);
    checkOutput("p1c0_selA", 32'(o_selA), 1);
    checkOutput("p1c0_wracc", 32'(o_WrAcc), 1);
    checkOutput("p1c0_operand", 32'(o_operand), 5);
    @(negedge i_clk);
    checkOutput("p1c1_addr", 32'(o_addr_pm), 1);
    checkOutput("p1c1_selA", 32'(o_selA), 2);
    checkOutput("p1c1_selB", 32'(o_selB), 1);
    checkOutput("p1c1_op", 32'(o_Op), 1);
    checkOutput("p1c1_operand", 32'(o_operand), 3);
    @(negedge i_clk);
    checkOutput("p1c2_addr", 32'(o_addr_pm), 2);
    checkOutput("p1c2_op", 32'(o_Op), 0);
    checkOutput("p1c2_wracc", 32'(o_WrAcc), 1);
    checkOutput("p1c2_operand", 32'(o_operand), 1);
    @(negedge i_clk);
    checkOutput("p1c3_addr", 32'(o_addr_pm), 3);
    checkOutput("p1c3_wracc", 32'(o_WrAcc), 0);
    checkOutput("p1c3_done", 32'(o_done), 0);
    @(negedge i_clk);
    checkOutput("p1_done", 32'(o_done), 1);
    checkOutput("p1_pc", 32'(o_addr_pm), 3);
    checkOutput("p1_cycles", 32'(o_cycles), 4);
    @(negedge i_clk);
    checkOutput("p1_frozen_pc", 32'(o_addr_pm), 3);
    checkOutput("p1_frozen_cycles", 32'(o_cycles), 4);
    checkOutput("halt_wracc", 32'(o_WrAcc), 0);

    // Restart from HALT, then a start pulse mid-run is ignored
    applyStimulus();
    checkOutput("rs_addr", 32'(o_addr_pm), 0);
    checkOutput("rs_cycles", 32'(o_cycles), 0);
    checkOutput("rs_done", 32'(o_done), 0);
    checkOutput("rs_selA", 32'(o_selA), 1);
    @(negedge i_clk);
    checkOutput("rs_c1_addr", 32'(o_addr_pm), 1);
    applyStimulus();
    checkOutput("midstart_addr", 32'(o_addr_pm), 2);
    checkOutput("midstart_cycles", 32'(o_cycles), 2);
    @(negedge i_clk);
    @(negedge i_clk);
    checkOutput("rs_done2", 32'(o_done), 1);
    checkOutput("rs_cycles2", 32'(o_cycles), 4);

    // Asynchronous reset during cycle 2 of program 1
    applyStimulus();
    @(negedge i_clk);
    @(negedge i_clk);
    checkOutput("ar_pre_addr", 32'(o_addr_pm), 2);
    #2 i_rst = 1'b0;
    #1;
    checkOutput("ar_addr", 32'(o_addr_pm), 0);
    checkOutput("ar_wracc", 32'(o_WrAcc), 0);
    checkOutput("ar_selA", 32'(o_selA), 0);
    checkOutput("ar_operand", 32'(o_operand), 0);
    checkOutput("ar_cycles", 32'(o_cycles), 0);
    checkOutput("ar_done", 32'(o_done), 0);
    @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    checkOutput("ar_idle_wracc", 32'(o_WrAcc), 0);
    applyStimulus();
    checkOutput("ar_rerun_addr", 32'(o_addr_pm), 0);
    checkOutput("ar_rerun_selA", 32'(o_selA), 1);
    repeat (4) @(negedge i_clk);
    checkOutput("ar_rerun_done", 32'(o_done), 1);
    checkOutput("ar_rerun_cycles", 32'(o_cycles), 4);

    // Program 2: LD 7; ADD 8; STO 9; HLT
    fillPm(16'h0000);
    pm[0] = {5'b00010, 11'd7};
    pm[1] = {5'b00100, 11'd8};
    pm[2] = {5'b00001, 11'd9};
    doReset();
    applyStimulus();
    checkOutput("p2c0_rdram", 32'(o_RdRam), 1);
    checkOutput("p2c0_selA", 32'(o_selA), 0);
    checkOutput("p2c0_wracc", 32'(o_WrAcc), 1);
    checkOutput("p2c0_operand", 32'(o_operand), 7);
    @(negedge i_clk);
    checkOutput("p2c1_rdram", 32'(o_RdRam), 1);
    checkOutput("p2c1_selA", 32'(o_selA), 2);
    checkOutput("p2c1_selB", 32'(o_selB), 0);
    checkOutput("p2c1_op", 32'(o_Op), 1);
    @(negedge i_clk);
    checkOutput("p2c2_wrram", 32'(o_WrRam), 1);
    checkOutput("p2c2_wracc", 32'(o_WrAcc), 0);
    checkOutput("p2c2_rdram", 32'(o_RdRam), 0);
    checkOutput("p2c2_operand", 32'(o_operand), 9);
    @(negedge i_clk);
    @(negedge i_clk);
    checkOutput("p2_done", 32'(o_done), 1);
    checkOutput("p2_cycles", 32'(o_cycles), 4);

    // Program 3: undefined opcode behaves as NOP, then HLT
    fillPm(16'h0000);
    pm[0] = {5'b11111, 11'h123};
    doReset();
    applyStimulus();
    checkOutput("p3_wracc", 32'(o_WrAcc), 0);
    checkOutput("p3_wrram", 32'(o_WrRam), 0);
    checkOutput("p3_rdram", 32'(o_RdRam), 0);
    checkOutput("p3_selA", 32'(o_selA), 0);
    checkOutput("p3_operand", 32'(o_operand), 32'h123);
    @(negedge i_clk);
    checkOutput("p3_c1_addr", 32'(o_addr_pm), 1);
    @(negedge i_clk);
    checkOutput("p3_done", 32'(o_done), 1);
    checkOutput("p3_pc", 32'(o_addr_pm), 1);
    checkOutput("p3_cycles", 32'(o_cycles), 2);

    // PC wrap and cycle-counter saturation on a NOP-only program
    fillPm(16'hF800);
    doReset();
    applyStimulus();
    repeat (2048) @(negedge i_clk);
    checkOutput("wrap_addr", 32'(o_addr_pm), 0);
    checkOutput("wrap_cycles", 32'(o_cycles), 2048);
    checkOutput("wrap_done", 32'(o_done), 0);
    repeat (65540 - 2048) @(negedge i_clk);
    checkOutput("sat_cycles", 32'(o_cycles), 32'hFFFF);
    checkOutput("sat_addr", 32'(o_addr_pm), 4);
    pm[4] = 16'h0000;
    @(negedge i_clk);
    checkOutput("sat_done", 32'(o_done), 1);
    checkOutput("sat_cycles_halt", 32'(o_cycles), 32'hFFFF);

`ifdef BIP_STEP_MODE_EN
    // Step mode: program 1 with i_step high every third cycle
    begin
      int exp_pc;
      loadProg1();
      doReset();
      applyStimulus();
      exp_pc = 0;
      for (int k = 0; k < 30; k++) begin
        if (o_done) break;
        i_step = ((k % 3) == 2);
        #1;
        checkOutput("step_addr", 32'(o_addr_pm), 32'(exp_pc));
        checkOutput("step_wracc", 32'(o_WrAcc), 32'(i_step && (exp_pc != 3)));
        if (i_step && exp_pc != 3) exp_pc++;
        @(negedge i_clk);
      end
      i_step = 1'b1;
      checkOutput("step_done", 32'(o_done), 1);
      checkOutput("step_pc", 32'(o_addr_pm), 3);
      checkOutput("step_cycles", 32'(o_cycles), 4);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
